// File: rtl/adc_serial_capture.sv
// ---------------------------------------------------------------------------
// adc_serial_capture
//
// Drives three serial pixel ADCs that share one chip select and one serial
// clock. Each start request runs one 16-bit frame, captures one sample per
// ADC, and pushes the three 12-bit samples into a downstream FIFO as a single
// 36-bit word.
//
// Parameters
//   HALF_DIV      clk cycles per SCLK half-period (1..255)
//   QUIET_CYCLES  clk cycles CS stays high after a frame before the next
//                 start is accepted (1..255)
//
// Ports
//   clk                      system clock, rising edge
//   reset                    asynchronous active-high reset
//   start                    one-cycle request for one three-channel frame
//   px0/1/2_adc_din          serial data from the three ADCs
//   CS                       shared chip select, active low
//   SCLK                     shared serial clock, idle high
//   fifo_full                downstream FIFO full
//   wr_en                    one-cycle FIFO write strobe
//   wr_data                  {ch2[11:0], ch1[11:0], ch0[11:0]}
//   busy                     high from CS assertion until the quiet period ends
//   overflow                 sticky: a frame was dropped on fifo_full
//   clr_ovf                  one-cycle clear of overflow
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module adc_serial_capture #(
    parameter int unsigned HALF_DIV     = 2,
    parameter int unsigned QUIET_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        px0_adc_din,
    input  logic        px1_adc_din,
    input  logic        px2_adc_din,
    output logic        CS,
    output logic        SCLK,
    input  logic        fifo_full,
    output logic        wr_en,
    output logic [35:0] wr_data,
    output logic        busy,
    output logic        overflow,
    input  logic        clr_ovf
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_WRITE,
        S_QUIET
    } state_t;

    // Terminal counts; an 8-bit counter covers the full 1..255 range.
    localparam logic [7:0] HALF_LAST  = 8'(HALF_DIV - 1);
    localparam logic [7:0] QUIET_LAST = 8'(QUIET_CYCLES - 1);

    state_t      r_state;
    logic [7:0]  r_cnt;       // half-period / quiet-period counter
    logic [4:0]  r_bit_cnt;   // completed SCLK periods, 0..15
    logic [15:0] r_sr0;
    logic [15:0] r_sr1;
    logic [15:0] r_sr2;
    logic        r_cs;
    logic        r_sclk;
    logic        r_busy;
    logic        r_ovf;
    logic [35:0] r_wr_data;

    logic        w_half_done;
    logic        w_quiet_done;

    assign w_half_done  = (r_cnt == HALF_LAST);
    assign w_quiet_done = (r_cnt == QUIET_LAST);

    assign CS       = r_cs;
    assign SCLK     = r_sclk;
    assign busy     = r_busy;
    assign overflow = r_ovf;
    assign wr_data  = r_wr_data;
    // The strobe follows fifo_full during the WRITE cycle itself, so a FIFO
    // that fills on that very cycle still causes a drop rather than a write.
    assign wr_en    = (r_state == S_WRITE) && !fifo_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_sr0     <= '0;
            r_sr1     <= '0;
            r_sr2     <= '0;
            r_cs      <= 1'b1;
            r_sclk    <= 1'b1;
            r_busy    <= 1'b0;
            r_ovf     <= 1'b0;
            r_wr_data <= '0;
        end else begin
            // Clear first so that a drop in the same cycle overrides it.
            if (clr_ovf) begin
                r_ovf <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    r_cs   <= 1'b1;
                    r_sclk <= 1'b1;
                    r_busy <= 1'b0;
                    if (start) begin
                        r_state <= S_SETUP;
                        r_cs    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                    end
                end

                // CS low with SCLK still high for one half-period.
                S_SETUP: begin
                    if (w_half_done) begin
                        r_state   <= S_SHIFT;
                        r_sclk    <= 1'b0;
                        r_cnt     <= '0;
                        r_bit_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                S_SHIFT: begin
                    if (!w_half_done) begin
                        r_cnt <= r_cnt + 8'd1;
                    end else begin
                        r_cnt <= '0;
                        if (!r_sclk) begin
                            // Low phase ends: SCLK rises and data is sampled
                            // on the same edge, MSB first.
                            r_sclk <= 1'b1;
                            r_sr0  <= {r_sr0[14:0], px0_adc_din};
                            r_sr1  <= {r_sr1[14:0], px1_adc_din};
                            r_sr2  <= {r_sr2[14:0], px2_adc_din};
                        end else if (r_bit_cnt == 5'd15) begin
                            // 16th high phase done; SCLK stays high and the
                            // four leading frame bits are dropped.
                            r_state   <= S_WRITE;
                            r_cs      <= 1'b1;
                            r_bit_cnt <= '0;
                            r_wr_data <= {r_sr2[11:0], r_sr1[11:0], r_sr0[11:0]};
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                            r_sclk    <= 1'b0;
                        end
                    end
                end

                S_WRITE: begin
                    if (fifo_full) begin
                        r_ovf <= 1'b1;
                    end
                    r_state <= S_QUIET;
                    r_cnt   <= '0;
                end

                S_QUIET: begin
                    if (w_quiet_done) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_cs    <= 1'b1;
                    r_sclk  <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_serial_capture.sv
// ---------------------------------------------------------------------------
// tb_adc_serial_capture
//
// Directed bench for adc_serial_capture. Instance A uses the default
// parameters (HALF_DIV=2, QUIET_CYCLES=4); instance B uses HALF_DIV=1,
// QUIET_CYCLES=1 for back-to-back framing. A simple ADC model per instance
// presents the MSB while CS is low and advances one bit after each SCLK rise.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_adc_serial_capture;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic reset;

    // Instance A
    logic        start_a;
    logic [2:0]  din_a;
    logic        cs_a;
    logic        sclk_a;
    logic        full_a;
    logic        wr_en_a;
    logic [35:0] wr_data_a;
    logic        busy_a;
    logic        ovf_a;
    logic        clr_a;

    // Instance B
    logic        start_b;
    logic [2:0]  din_b;
    logic        cs_b;
    logic        sclk_b;
    logic        full_b;
    logic        wr_en_b;
    logic [35:0] wr_data_b;
    logic        busy_b;
    logic        ovf_b;
    logic        clr_b;

    adc_serial_capture #(.HALF_DIV(2), .QUIET_CYCLES(4)) u_dut_a (
        .clk         (clk),
        .reset       (reset),
        .start       (start_a),
        .px0_adc_din (din_a[0]),
        .px1_adc_din (din_a[1]),
        .px2_adc_din (din_a[2]),
        .CS          (cs_a),
        .SCLK        (sclk_a),
        .fifo_full   (full_a),
        .wr_en       (wr_en_a),
        .wr_data     (wr_data_a),
        .busy        (busy_a),
        .overflow    (ovf_a),
        .clr_ovf     (clr_a)
    );

    adc_serial_capture #(.HALF_DIV(1), .QUIET_CYCLES(1)) u_dut_b (
        .clk         (clk),
        .reset       (reset),
        .start       (start_b),
        .px0_adc_din (din_b[0]),
        .px1_adc_din (din_b[1]),
        .px2_adc_din (din_b[2]),
        .CS          (cs_b),
        .SCLK        (sclk_b),
        .fifo_full   (full_b),
        .wr_en       (wr_en_b),
        .wr_data     (wr_data_b),
        .busy        (busy_b),
        .overflow    (ovf_b),
        .clr_ovf     (clr_b)
    );

    // ADC models: words presented by each channel
    logic [15:0] wa [3];
    logic [15:0] wb [3];
    int   idx_a   = 15;
    int   idx_b   = 15;
    int   rises_a = 0;
    logic prev_a  = 1'b1;
    logic prev_b  = 1'b1;

    always @(negedge clk) begin
        if (cs_a) begin
            idx_a = 15;
        end else if (sclk_a && !prev_a) begin
            idx_a   = idx_a - 1;
            rises_a = rises_a + 1;
        end
        prev_a = sclk_a;
        for (int k = 0; k < 3; k++) begin
            din_a[k] = (idx_a >= 0) ? wa[k][idx_a] : 1'b0;
        end

        if (cs_b) begin
            idx_b = 15;
        end else if (sclk_b && !prev_b) begin
            idx_b = idx_b - 1;
        end
        prev_b = sclk_b;
        for (int k = 0; k < 3; k++) begin
            din_b[k] = (idx_b >= 0) ? wb[k][idx_b] : 1'b0;
        end
    end

    int          n_tests = 0;
    int          n_fail  = 0;

    int          wr_cnt;
    int          wr_cyc;
    logic [35:0] wr_val;
    int          busy_low;
    int          r0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Runs one frame on instance A. Caller is 1 time unit after a rising
    // edge; that cycle is cycle 0. Optional extra starts, a reset pulse and a
    // clr_ovf pulse can be placed on given cycles (-1 = none).
    task automatic run_a(input int n, input int s1, input int s2,
                         input int rc, input int clr_cyc);
        wr_cnt   = 0;
        wr_cyc   = -1;
        wr_val   = '0;
        busy_low = -1;
        start_a  = 1'b1;
        for (int c = 1; c <= n; c++) begin
            @(posedge clk);
            #1;
            if (c == rc + 1) reset = 1'b0;
            if (c == 1) begin
                check("cs_low_c1", 64'(cs_a), 64'(0));
                check("busy_c1", 64'(busy_a), 64'(1));
            end
            if (wr_en_a === 1'b1) begin
                wr_cnt++;
                wr_cyc = c;
                wr_val = wr_data_a;
            end
            if (busy_a === 1'b0 && busy_low < 0) busy_low = c;
            start_a = (c == s1 || c == s2);
            clr_a   = (c == clr_cyc);
            if (c == rc) begin
                reset = 1'b1;
                #1;
                check("rst_mid_cs", 64'(cs_a), 64'(1));
                check("rst_mid_sclk", 64'(sclk_a), 64'(1));
                check("rst_mid_wr_en", 64'(wr_en_a), 64'(0));
            end
        end
        start_a = 1'b0;
        clr_a   = 1'b0;
    endtask

    int          n_st;
    int          wr_cnt_b;
    int          wr_cyc_b [4];
    logic [35:0] last_b;
    int          gap_min;
    int          run_len;
    logic        prev_cs;

    initial begin
        reset   = 1'b1;
        start_a = 1'b0;
        full_a  = 1'b0;
        clr_a   = 1'b0;
        start_b = 1'b0;
        full_b  = 1'b0;
        clr_b   = 1'b0;
        wa[0] = 16'h0ABC; wa[1] = 16'h0123; wa[2] = 16'h0FFF;
        wb[0] = 16'h8321; wb[1] = 16'h7654; wb[2] = 16'h0987;

        repeat (3) @(posedge clk);
        #1;
        check("rst_cs", 64'(cs_a), 64'(1));
        check("rst_sclk", 64'(sclk_a), 64'(1));
        check("rst_wr_en", 64'(wr_en_a), 64'(0));
        check("rst_busy", 64'(busy_a), 64'(0));
        check("rst_ovf", 64'(ovf_a), 64'(0));
        check("rst_wr_data", 64'(wr_data_a), 64'(0));
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Basic frame: latency, data and SCLK count
        r0 = rises_a;
        run_a(80, -1, -1, -1, -1);
        check("f1_wr_cnt", 64'(wr_cnt), 64'(1));
        check("f1_wr_cyc", 64'(wr_cyc), 64'(67));
        check("f1_wr_data", 64'(wr_val), 64'(36'hFFF123ABC));
        check("f1_sclk_rises", 64'(rises_a - r0), 64'(16));
        check("f1_busy_low", 64'(busy_low), 64'(72));
        check("f1_data_hold", 64'(wr_data_a), 64'(36'hFFF123ABC));
        check("f1_idle_cs", 64'(cs_a), 64'(1));

        // FIFO full: drop, sticky overflow, clear
        full_a = 1'b1;
        run_a(80, -1, -1, -1, -1);
        full_a = 1'b0;
        check("full_wr_cnt", 64'(wr_cnt), 64'(0));
        check("full_ovf", 64'(ovf_a), 64'(1));
        clr_a = 1'b1;
        @(posedge clk);
        #1;
        clr_a = 1'b0;
        check("clr_ovf", 64'(ovf_a), 64'(0));

        // Clear in the same cycle as a drop: set wins
        full_a = 1'b1;
        run_a(80, -1, -1, -1, 67);
        full_a = 1'b0;
        check("setwin_ovf", 64'(ovf_a), 64'(1));
        clr_a = 1'b1;
        @(posedge clk);
        #1;
        clr_a = 1'b0;
        check("setwin_clr", 64'(ovf_a), 64'(0));

        // Starts while busy are ignored, not queued
        run_a(90, 5, 70, -1, -1);
        check("ign_wr_cnt", 64'(wr_cnt), 64'(1));
        check("ign_wr_cyc", 64'(wr_cyc), 64'(67));
        check("ign_busy_low", 64'(busy_low), 64'(72));
        check("ign_no_queue", 64'(busy_a), 64'(0));

        // Reset mid-frame aborts; next frame is complete and correct,
        // including dropped leading bits on ch0
        wa[0] = 16'hF555; wa[1] = 16'h0A5A; wa[2] = 16'h1234;
        run_a(50, -1, -1, 30, -1);
        check("abort_wr_cnt", 64'(wr_cnt), 64'(0));
        check("abort_idle", 64'(busy_a), 64'(0));
        run_a(80, -1, -1, -1, -1);
        check("after_rst_wr_cnt", 64'(wr_cnt), 64'(1));
        check("after_rst_wr_cyc", 64'(wr_cyc), 64'(67));
        check("after_rst_data", 64'(wr_val), 64'(36'h234A5A555));

        // Instance B: back-to-back frames, start as soon as busy falls
        n_st     = 0;
        wr_cnt_b = 0;
        last_b   = '0;
        gap_min  = 1000;
        run_len  = 0;
        prev_cs  = 1'b1;
        for (int k = 0; k < 4; k++) wr_cyc_b[k] = -1;
        for (int c = 0; c < 115; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            if (wr_en_b === 1'b1) begin
                if (wr_cnt_b < 4) wr_cyc_b[wr_cnt_b] = c;
                wr_cnt_b++;
                last_b = wr_data_b;
            end
            if (cs_b === 1'b1) begin
                run_len++;
            end else begin
                if (prev_cs && n_st >= 2 && run_len < gap_min) gap_min = run_len;
                run_len = 0;
            end
            prev_cs = cs_b;
            start_b = (busy_b === 1'b0) && (n_st < 3);
            if (start_b) n_st++;
        end
        start_b = 1'b0;
        check("b2b_wr_cnt", 64'(wr_cnt_b), 64'(3));
        check("b2b_wr0", 64'(wr_cyc_b[0]), 64'(34));
        check("b2b_wr1", 64'(wr_cyc_b[1]), 64'(70));
        check("b2b_wr2", 64'(wr_cyc_b[2]), 64'(106));
        check("b2b_cs_gap", 64'(gap_min >= 2 && gap_min < 1000), 64'(1));
        check("b2b_data", 64'(last_b), 64'(36'h987654321));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_serial_capture.md
ADC_SERIAL_CAPTURE -- requirements
Module: adc_serial_capture

Interface
REQ-001 SHALL have parameter HALF_DIV, default 2: clk cycles per SCLK half-period; legal range 1..255.
REQ-002 SHALL have parameter QUIET_CYCLES, default 4: clk cycles CS held high after each frame before the next start is accepted; legal range 1..255.
REQ-003 clk  input  1  system clock, 50 MHz; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 start  input  1  one-cycle request for one three-channel conversion.
REQ-006 px0_adc_din, px1_adc_din, px2_adc_din  input  1 each  serial data from the three pixel ADCs.
REQ-007 CS  output  1  shared ADC chip select, active low.
REQ-008 SCLK  output  1  shared ADC serial clock, idle high.
REQ-009 fifo_full  input  1  downstream sample FIFO full.
REQ-010 wr_en  output  1  one-cycle FIFO write strobe.
REQ-011 wr_data  output  36  {ch2[11:0], ch1[11:0], ch0[11:0]}, valid while wr_en is high.
REQ-012 busy  output  1  high from CS assertion until the quiet period ends.
REQ-013 overflow  output  1  sticky flag: a frame was dropped because fifo_full was high.
REQ-014 clr_ovf  input  1  one-cycle clear of overflow.

Function
REQ-015 SHALL implement states IDLE, SETUP, SHIFT, WRITE, QUIET.
REQ-016 IDLE: CS=1, SCLK=1, busy=0; start=1 -> SETUP on the next edge; start outside IDLE SHALL be ignored with no queuing.
REQ-017 SETUP: CS=0, SCLK=1, busy=1, lasting HALF_DIV cycles, then SHIFT.
REQ-018 SHIFT: 16 SCLK periods, each SCLK=0 for HALF_DIV cycles followed by SCLK=1 for HALF_DIV cycles; CS=0 throughout.
REQ-019 Each din SHALL be captured into its 16-bit shift register on the clk edge where SCLK goes 0->1, MSB first.
REQ-020 After the 16th high phase completes -> WRITE; frame bits 15..12 are discarded; sample = bits 11..0.
REQ-021 WRITE lasts 1 cycle with CS=1 and SCLK=1: if fifo_full=0, wr_en=1 with wr_data; if fifo_full=1, wr_en=0 and overflow set to 1.
REQ-022 QUIET: CS=1, SCLK=1, busy=1 for QUIET_CYCLES cycles, then IDLE.
REQ-023 Latency: start high in cycle 0 -> CS low in cycle 1 -> wr_en in cycle 1+33*HALF_DIV (cycle 67 at HALF_DIV=2) -> busy low in cycle 2+33*HALF_DIV+QUIET_CYCLES.
REQ-024 wr_data SHALL hold its last value outside WRITE; wr_en SHALL never exceed one cycle per frame.
REQ-025 clr_ovf=1 clears overflow; clr_ovf and a same-cycle drop SHALL leave overflow=1 (set wins).
REQ-026 Half-period counter and bit counter SHALL be sized for the parameter maxima and never wrap within a frame.

Reset
REQ-027 reset=1 SHALL force IDLE immediately: CS=1, SCLK=1, wr_en=0, busy=0, overflow=0, wr_data=0, counters and shift registers=0.
REQ-028 reset asserted mid-frame SHALL abort the frame with no write; the first start after release begins a full new frame.

Verification
REQ-029 HALF_DIV=2, start pulse, ADC models return 0x0ABC/0x0123/0x0FFF -> wr_en only in cycle 67, wr_data=0xFFF123ABC, 16 SCLK rising edges while CS=0.
REQ-030 fifo_full=1 throughout a frame -> wr_en stays 0, overflow=1; clr_ovf pulse -> overflow=0.
REQ-031 start pulses in cycles 5 and 70 after an accepted start -> ignored; exactly one wr_en; busy low in cycle 72.
REQ-032 reset pulse in cycle 30 of a frame -> CS=1, SCLK=1 immediately; no wr_en; a following start yields a correct frame.
REQ-033 HALF_DIV=1, QUIET_CYCLES=1, back-to-back starts issued as soon as busy falls -> one wr_en per frame every 36 cycles, CS high >=2 cycles between frames.
REQ-034 Frame with nonzero leading bits 0xF555 on ch0 -> wr_data[11:0]=0x555.
